// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux8
//  Purpose  : Receive side of an 8-slot TDM link. Serial slot beats in,
//             frame committed to eight parallel words at once. Defining
//             TDM_PARITY_EN adds a 9th even-parity beat to every frame.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux8 #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_sync,
    input  logic [WIDTH-1:0]   in_data,
    output logic [8*WIDTH-1:0] y_bus,
    output logic               frame_valid,
    output logic               sync_err,
`ifdef TDM_PARITY_EN
    output logic               par_err,
`endif
    output logic               busy
);

`ifdef TDM_PARITY_EN
    localparam int CNT_W    = 4;
    localparam int N_SHADOW = 8;
`else
    localparam int CNT_W    = 3;
    localparam int N_SHADOW = 7;
`endif
    // Index of the beat that closes a frame: data slot 7, or the parity beat.
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_SHADOW);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                slot_cnt_q, slot_cnt_d;
    logic [N_SHADOW-1:0][WIDTH-1:0]  shadow_q, shadow_d;
    logic [8*WIDTH-1:0]              y_bus_q, y_bus_d;
    logic                            frame_valid_q, frame_valid_d;
    logic                            sync_err_q, sync_err_d;
    logic                            busy_q, busy_d;
`ifdef TDM_PARITY_EN
    logic                            par_err_q, par_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        slot_cnt_d    = slot_cnt_q;
        shadow_d      = shadow_q;
        y_bus_d       = y_bus_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
`ifdef TDM_PARITY_EN
        par_err_d     = 1'b0;
`endif
        if (in_valid) begin
            if (in_sync) begin
                // A sync beat always restarts the frame; mid-frame it also flags an error.
                if (state_q == RECV && slot_cnt_q != '0) begin
                    sync_err_d = 1'b1;
                end
                shadow_d[0] = in_data;
                slot_cnt_d  = CNT_W'(1);
                state_d     = RECV;
            end else if (state_q == RECV) begin
                if (slot_cnt_q == '0) begin
                    sync_err_d = 1'b1;
                    state_d    = HUNT;
                end else if (slot_cnt_q == C_LAST) begin
                    slot_cnt_d = '0;
`ifdef TDM_PARITY_EN
                    if ((^shadow_q) == in_data[0]) begin
                        y_bus_d       = shadow_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        par_err_d = 1'b1;
                    end
`else
                    y_bus_d       = {in_data, shadow_q};
                    frame_valid_d = 1'b1;
`endif
                end else begin
                    for (int k = 1; k < N_SHADOW; k++) begin
                        if (slot_cnt_q == CNT_W'(k)) begin
                            shadow_d[k] = in_data;
                        end
                    end
                    slot_cnt_d = slot_cnt_q + CNT_W'(1);
                end
            end
        end
        busy_d = (slot_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_cnt_q    <= '0;
            shadow_q      <= '0;
            y_bus_q       <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef TDM_PARITY_EN
            par_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            shadow_q      <= shadow_d;
            y_bus_q       <= y_bus_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            busy_q        <= busy_d;
`ifdef TDM_PARITY_EN
            par_err_q     <= par_err_d;
`endif
        end
    end

    assign y_bus       = y_bus_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign busy        = busy_q;
`ifdef TDM_PARITY_EN
    assign par_err     = par_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux8
//  Purpose  : Directed and random stimulus for tdm_demux8 (WIDTH=4, default
//             8-beat framing) checked against a frame-queue reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux8;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_sync = 1'b0;
    logic [WIDTH-1:0]   in_data = '0;
    logic [8*WIDTH-1:0] y_bus;
    logic               frame_valid;
    logic               sync_err;
    logic               busy;

    tdm_demux8 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sync     (in_sync),
        .in_data     (in_data),
        .y_bus       (y_bus),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_fail  = 0;
    int unsigned fv_seen = 0;

    // Reference model: a list of words gathered so far in the current frame.
    logic [WIDTH-1:0]   frame[$];
    bit                 hunting = 1'b1;
    logic [8*WIDTH-1:0] exp_y   = '0;
    logic               exp_fv  = 1'b0;
    logic               exp_err = 1'b0;
    logic               exp_busy = 1'b0;

    task automatic chk(input string tag, input logic [8*WIDTH-1:0] obs, input logic [8*WIDTH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rn, input logic v, input logic s, input logic [WIDTH-1:0] d);
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (!rn) begin
            exp_y = '0;
            frame.delete();
            hunting = 1'b1;
        end else if (v) begin
            if (s) begin
                if (!hunting && frame.size() != 0) exp_err = 1'b1;
                frame.delete();
                frame.push_back(d);
                hunting = 1'b0;
            end else if (!hunting) begin
                if (frame.size() == 0) begin
                    exp_err = 1'b1;
                    hunting = 1'b1;
                end else begin
                    frame.push_back(d);
                    if (frame.size() == 8) begin
                        for (int k = 0; k < 8; k++) exp_y[k*WIDTH +: WIDTH] = frame[k];
                        exp_fv = 1'b1;
                        frame.delete();
                    end
                end
            end
        end
        exp_busy = (frame.size() != 0);
    endtask

    task automatic step(input logic rn, input logic v, input logic s, input logic [WIDTH-1:0] d);
        rst_n    = rn;
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        model(rn, v, s, d);
        #1;
        if (frame_valid === 1'b1) fv_seen++;
        chk("y_bus",       y_bus,                   exp_y);
        chk("frame_valid", {31'b0, frame_valid},    {31'b0, exp_fv});
        chk("sync_err",    {31'b0, sync_err},       {31'b0, exp_err});
        chk("busy",        {31'b0, busy},           {31'b0, exp_busy});
    endtask

    initial begin
        int unsigned fv_base;
        int unsigned pos;
        logic        s;
        logic        v;

        // Reset held 2 cycles with a sync beat present: nothing is captured.
        step(1'b0, 1'b1, 1'b1, 4'hF);
        step(1'b0, 1'b1, 1'b1, 4'hE);
        chk("reset_y", y_bus, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);

        // Reset after five beats discards the partial frame.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k == 0, 4'(k + 9));
        chk("mid_busy_before", {31'b0, busy}, 32'h1);
        step(1'b0, 1'b1, 1'b0, 4'h3);
        chk("mid_reset_y", y_bus, 32'h0);
        chk("mid_reset_busy", {31'b0, busy}, 32'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 4'h5);
        chk("mid_reset_nofv", {31'b0, frame_valid}, 32'h0);

        // Clean frame 1..8.
        fv_base = fv_seen;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, k == 0, 4'(k + 1));
        chk("clean_y", y_bus, 32'h87654321);
        chk("clean_fv", {31'b0, frame_valid}, 32'h1);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        chk("clean_fv_one", {31'b0, frame_valid}, 32'h0);

        // Stalls between beats, then 8..1 back to back.
        step(1'b0, 1'b0, 1'b0, 4'h0);
        fv_base = fv_seen;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, k == 0, 4'(k + 1));
            if (k % 3 == 1) begin
                step(1'b1, 1'b0, 1'b1, 4'hA);
                step(1'b1, 1'b0, 1'b0, 4'hB);
            end
        end
        chk("stall_y", y_bus, 32'h87654321);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, k == 0, 4'(8 - k));
        chk("b2b_y", y_bus, 32'h12345678);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        chk("b2b_fv_count", 32'(fv_seen - fv_base), 32'd2);

        // Hunt then early sync.
        step(1'b0, 1'b0, 1'b0, 4'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 4'h7);
        chk("hunt_busy", {31'b0, busy}, 32'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, k == 0, 4'h1);
        step(1'b1, 1'b1, 1'b1, 4'hA);
        chk("early_sync_err", {31'b0, sync_err}, 32'h1);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 4'(k + 1));
        chk("early_sync_y", y_bus, 32'h7654321A);

        // Lost sync: a non-sync beat at a frame boundary.
        step(1'b1, 1'b1, 1'b0, 4'h2);
        chk("lost_sync_err", {31'b0, sync_err}, 32'h1);

        // Random traffic: mostly well-formed frames with occasional faults.
        pos = 0;
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = (pos == 0) ^ ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) begin
                step(1'b0, v, s, 4'($urandom));
                pos = 0;
            end else begin
                step(1'b1, v, s, 4'($urandom));
                if (v) pos = s ? 1 : ((pos + 1) % 8);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
